// File: rtl/aes128_enc_nsbox.sv
// AES-128 encryption core with NSBOX shared state S-boxes (16/NSBOX substitution cycles per round).
// The key schedule runs beside the datapath on its own four S-boxes, one round key per round.
module aes128_enc_nsbox #(
  parameter int NSBOX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] text_out,
  output logic         busy
);
  localparam int SPR = 16 / NSBOX;

  if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4 || NSBOX == 8 || NSBOX == 16)) begin : g_bad_nsbox
    $error("aes128_enc_nsbox: NSBOX must be 1, 2, 4, 8 or 16");
  end

  // Byte i of a block is FIPS byte i (row i%4, column i/4).
  typedef logic [15:0][7:0] blk_t;
  typedef enum logic [1:0] {IDLE, LOAD, SUB, UPD} fsm_t;

  fsm_t fsm, fsm_nxt;
  blk_t st, sub, rk, nk;
  logic [3:0] round, scnt;
  logic fire;
  logic [NSBOX-1:0][7:0] sb_in, sb_out;
  logic [3:0][7:0] ks_in, ks_out;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic blk_t to_blk(input logic [127:0] x);
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = x[127-8*i -: 8];
    return b;
  endfunction

  function automatic logic [127:0] from_blk(input blk_t b);
    logic [127:0] x;
    for (int i = 0; i < 16; i++) x[127-8*i -: 8] = b[i];
    return x;
  endfunction

  function automatic blk_t shift_rows(input blk_t b);
    blk_t o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) o[r+4*c] = b[r+4*((c+r)%4)];
    return o;
  endfunction

  function automatic blk_t mix_cols(input blk_t b);
    blk_t o;
    for (int c = 0; c < 4; c++) begin
      o[4*c]   = xt(b[4*c]) ^ xt(b[4*c+1]) ^ b[4*c+1] ^ b[4*c+2] ^ b[4*c+3];
      o[4*c+1] = b[4*c] ^ xt(b[4*c+1]) ^ xt(b[4*c+2]) ^ b[4*c+2] ^ b[4*c+3];
      o[4*c+2] = b[4*c] ^ b[4*c+1] ^ xt(b[4*c+2]) ^ xt(b[4*c+3]) ^ b[4*c+3];
      o[4*c+3] = xt(b[4*c]) ^ b[4*c] ^ b[4*c+1] ^ b[4*c+2] ^ xt(b[4*c+3]);
    end
    return o;
  endfunction

  function automatic logic [7:0] rcon_f(input logic [3:0] r);
    case (r)
      4'd1:  return 8'h01;
      4'd2:  return 8'h02;
      4'd3:  return 8'h04;
      4'd4:  return 8'h08;
      4'd5:  return 8'h10;
      4'd6:  return 8'h20;
      4'd7:  return 8'h40;
      4'd8:  return 8'h80;
      4'd9:  return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  for (genvar j = 0; j < NSBOX; j++) begin : g_sbox
    aes_sbox u_sbox (.a(sb_in[j]), .y(sb_out[j]));
  end
  for (genvar j = 0; j < 4; j++) begin : g_ksbox
    aes_sbox u_ksbox (.a(ks_in[j]), .y(ks_out[j]));
  end

  always_comb begin
    sb_in = '0;
    for (int j = 0; j < NSBOX; j++) sb_in[j] = st[4'(int'(scnt) * NSBOX + j)];
  end

  // RotWord of the last key word feeds the key S-boxes.
  assign ks_in = {rk[12], rk[15], rk[14], rk[13]};

  always_comb begin
    nk = rk;
    for (int i = 0; i < 4; i++) nk[i] = rk[i] ^ ks_out[i] ^ ((i == 0) ? rcon_f(round) : 8'h00);
    for (int i = 4; i < 16; i++) nk[i] = rk[i] ^ nk[i-4];
  end

  assign fire     = (fsm == UPD) && (round == 4'd10) && (!out_valid || out_ready);
  assign in_ready = (fsm == IDLE) && !rst;
  assign busy     = (fsm != IDLE);

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (in_valid) fsm_nxt = LOAD;
      LOAD: fsm_nxt = SUB;
      SUB:  if (scnt == 4'(SPR - 1)) fsm_nxt = UPD;
      UPD:  if (round != 4'd10) fsm_nxt = SUB;
            else if (fire) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= IDLE;
    else     fsm <= fsm_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= '0;
      sub       <= '0;
      rk        <= '0;
      round     <= '0;
      scnt      <= '0;
      text_out  <= '0;
      out_valid <= 1'b0;
    end else begin
      // A final round completing on the same edge overrides this clear.
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (fsm)
        IDLE: if (in_valid) begin
          st <= to_blk(text_in);
          rk <= to_blk(key);
        end
        LOAD: begin
          st    <= st ^ rk;
          round <= 4'd1;
          scnt  <= '0;
        end
        SUB: begin
          for (int j = 0; j < NSBOX; j++) sub[4'(int'(scnt) * NSBOX + j)] <= sb_out[j];
          scnt <= (scnt == 4'(SPR - 1)) ? 4'd0 : scnt + 4'd1;
        end
        UPD: begin
          if (round != 4'd10) begin
            rk    <= nk;
            st    <= mix_cols(shift_rows(sub)) ^ nk;
            round <= round + 4'd1;
            scnt  <= '0;
          end else if (fire) begin
            text_out  <= from_blk(shift_rows(sub) ^ nk);
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// AES S-box: GF(2^8) inverse as x^254 followed by the affine transform.
module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
    logic [7:0] p, m;
    p = '0;
    m = x;
    for (int i = 0; i < 8; i++) begin
      if (z[i]) p = p ^ m;
      m = {m[6:0], 1'b0} ^ (m[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  assign x2   = gmul(a, a);
  assign x3   = gmul(x2, a);
  assign x6   = gmul(x3, x3);
  assign x12  = gmul(x6, x6);
  assign x15  = gmul(x12, x3);
  assign x30  = gmul(x15, x15);
  assign x60  = gmul(x30, x30);
  assign x120 = gmul(x60, x60);
  assign x240 = gmul(x120, x120);
  assign x252 = gmul(x240, x12);
  assign inv  = gmul(x252, x2);
  assign y    = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
endmodule

// File: tb/tb_aes128_enc_nsbox.sv
// Directed bench: FIPS-197 vectors across all NSBOX sizes, latency, backpressure, reset and input hygiene.
module tb_aes128_enc_nsbox;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] key = '0, text_in = '0;
  logic [4:0] in_ready_a, out_valid_a, busy_a;
  logic [127:0] text_out_a [5];

  int n_vec = 0, n_err = 0;
  int n;
  int lat [5];

  always #5 clk = ~clk;

  // Index g runs NSBOX = 1<<g; index 2 (NSBOX=4) is the main device.
  for (genvar g = 0; g < 5; g++) begin : g_dut
    aes128_enc_nsbox #(.NSBOX(1 << g)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a[g]),
      .key(key), .text_in(text_in), .out_valid(out_valid_a[g]), .out_ready(out_ready),
      .text_out(text_out_a[g]), .busy(busy_a[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] k, input logic [127:0] p);
    key      = k;
    text_in  = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while (!out_valid_a[2] && cnt < 400);
    chk(tag, 128'(out_valid_a[2]), 128'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready_a), 128'd0);
    chk("rst_out_valid", 128'(out_valid_a), 128'd0);
    chk("rst_busy", 128'(busy_a), 128'd0);
    chk("rst_text_out", text_out_a[2], 128'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 128'(in_ready_a), 128'h1f);

    // FIPS-197 C.1 on every S-box count, with per-size latency
    for (int g = 0; g < 5; g++) lat[g] = 0;
    send(K1, P1);
    n = 0;
    while (n < 200 && out_valid_a != 5'h1f) begin
      tick();
      n++;
      for (int g = 0; g < 5; g++) if (out_valid_a[g] && lat[g] == 0) lat[g] = n;
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("c1_lat_nsbox%0d", 1 << g), 128'(lat[g]), 128'(1 + 10 * (16 / (1 << g) + 1)));
      chk($sformatf("c1_ct_nsbox%0d", 1 << g), text_out_a[g], C1);
    end
    out_ready = 1'b1;
    tick();
    chk("c1_consumed", 128'(out_valid_a), 128'd0);
    out_ready = 1'b0;

    // FIPS-197 B with inputs scrambled and stray in_valid pulses while busy
    send(K2, P2);
    chk("b_in_ready_busy", 128'(in_ready_a[2]), 128'd0);
    chk("b_busy", 128'(busy_a[2]), 128'd1);
    n = 0;
    do begin
      key      = {$urandom, $urandom, $urandom, $urandom};
      text_in  = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'($urandom_range(0, 1));
      tick();
      n++;
    end while (!out_valid_a[2] && n < 400);
    in_valid = 1'b0;
    chk("b_latency", 128'(n), 128'd51);
    chk("b_ct", text_out_a[2], C2);
    chk("b_in_ready_done", 128'(in_ready_a[2]), 128'd1);
    out_ready = 1'b1;
    tick();
    chk("b_consumed", 128'(out_valid_a[2]), 128'd0);
    out_ready = 1'b0;

    // Backpressure: block 1 held, block 2 stalls in its final round
    send(K1, P1);
    wait_out("bp_blk1_done", n);
    send(K2, P2);
    repeat (60) tick();
    chk("bp_stall_busy", 128'(busy_a[2]), 128'd1);
    chk("bp_stall_in_ready", 128'(in_ready_a[2]), 128'd0);
    chk("bp_hold_valid", 128'(out_valid_a[2]), 128'd1);
    chk("bp_hold_ct", text_out_a[2], C1);
    out_ready = 1'b1;
    tick();
    chk("bp_gapless_valid", 128'(out_valid_a[2]), 128'd1);
    chk("bp_blk2_ct", text_out_a[2], C2);
    chk("bp_idle", 128'(busy_a[2]), 128'd0);
    tick();
    chk("bp_drained", 128'(out_valid_a[2]), 128'd0);
    out_ready = 1'b0;

    // Consume of block 1 coincides with completion of block 2
    send(K2, P2);
    wait_out("sim_blk1_done", n);
    send(K1, P1);
    repeat (50) tick();
    chk("sim_pre_valid", 128'(out_valid_a[2]), 128'd1);
    chk("sim_pre_ct", text_out_a[2], C2);
    out_ready = 1'b1;
    tick();
    chk("sim_valid", 128'(out_valid_a[2]), 128'd1);
    chk("sim_ct", text_out_a[2], C1);
    out_ready = 1'b0;

    // Reset in round 5 SUB with a ciphertext still pending
    send(K2, P2);
    repeat (23) tick();
    rst = 1'b1;
    #2;
    chk("rr_out_valid", 128'(out_valid_a), 128'd0);
    chk("rr_busy", 128'(busy_a), 128'd0);
    chk("rr_in_ready_held", 128'(in_ready_a), 128'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rr_in_ready", 128'(in_ready_a), 128'h1f);
    send(K1, P1);
    wait_out("rr_done", n);
    chk("rr_latency", 128'(n), 128'd51);
    chk("rr_ct", text_out_a[2], C1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
